calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
Keypad-driven control FSM that sits between the key decoder and the arithmetic unit.
- Builds signed decimal operands A and B (±999) from key events and latches the operator.
- Issues a one-cycle computestrobe to the ALU and captures its 21-bit result.
- Drives the value to display, with busy and error status for the display mux.

Parameters:
- OPW, 11, operand width (signed two's complement, ±999 fits).
- RESW, 21, result width (±998001 fits).
- MAXDIG, 3, maximum digits per operand.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle pulse; key_code is valid this cycle.
- key_code  in  5  0–9 digit, 10 add, 11 subtract, 12 multiply, 13 divide, 14 negate, 15 equals, 16 clear; 17–31 ignored.
- regA  out  OPW  operand A to ALU (registered).
- regB  out  OPW  operand B to ALU (registered).
- opcode  out  2  to ALU: 00 add, 01 subtract, 10 multiply, 11 divide.
- computestrobe  out  1  one-cycle ALU compute request.
- alu_result  in  RESW  ALU result; valid the cycle after the computestrobe edge.
- display_value  out  RESW  signed value to display.
- busy  out  1  high in EXEC/WAIT; keys are dropped.
- error  out  1  high in ERR state.

Behaviour:
- Reset (synchronous, active-high, overrides everything including mid-operation):
  - state=ENTER_A; regA=regB=0; opcode=00; computestrobe=0.
  - display_value=0; busy=0; error=0; digit count=0.
- States: ENTER_A, ENTER_B, EXEC, WAIT, SHOW, ERR.
- Digit key (ENTER_A/ENTER_B):
  - If count<MAXDIG: magnitude=magnitude*10+d, count++.
  - Otherwise the digit is ignored.
  - Sign is kept separately; the operand register holds the signed value.
- Negate key: toggles the sign of the current operand. Allowed with count=0; then -0 is stored as 0 with sign flag set.
- Operator key:
  - In ENTER_A: latch opcode, clear B entry, go to ENTER_B.
  - In ENTER_B with count=0: replace opcode.
  - In ENTER_B with count>0: ignored.
- Equals key:
  - In ENTER_A: ignored.
  - In ENTER_B: if opcode=11 (divide is not supported by the ALU), go to ERR and assert no strobe. Otherwise go to EXEC.
- EXEC: computestrobe=1 for exactly one cycle; regA, regB and opcode are held stable; next state WAIT.
- WAIT: alu_result is sampled at the end of this cycle; next state SHOW.
- Latency: display_value is updated two cycles after the computestrobe cycle.
- SHOW: display_value = captured result.
  - Digit key: start a new A (entry cleared, then the digit applied); go to ENTER_A.
  - Operator key: see CHAIN_EN; without it, ignored.
- ERR: display_value=0, error=1. Only clear or reset leave ERR.
- Clear key (any state except EXEC/WAIT): same effect as reset at the next edge.
- While busy (EXEC/WAIT): every key, including clear, is dropped with no memory of it.
- Display while entering: ENTER_A shows signed A; ENTER_B shows signed B.
- Simultaneous events: reset beats key_valid. Only one key is accepted per cycle.

Optional Feature:
- Macro: CALC_CHAIN_EN.
- Defined, operator key in SHOW:
  - If the captured result is within -999..+999: regA=result, latch opcode, go to ENTER_B.
  - Otherwise go to ERR (operand overflow).
- Undefined: operator key in SHOW is ignored; no range-compare logic is built.

Decomposition:
- Package calc_pkg:
  - key-code constants;
  - opcode constants matching the ALU (add 00, subtract 01, multiply 10, divide 11);
  - state enum;
  - OPW, RESW and MAXDIG defaults;
  - operand limit constant 999.
- Sub-module calc_entry_accum:
  - Holds digit accumulation, sign toggle, count saturation and clear.
  - Outputs the signed OPW value.
  - Instantiated once and reused for A and B via a clear/select control.

Test Plan:
- Keys 1,2,add,3,4,equals → one computestrobe pulse with regA=12, regB=34, opcode=00; with a simple registered-ALU model returning 46, display_value=46 two cycles after the pulse.
- Keys 9,9,9,negate,multiply,9,9,9,equals → regA=-999, regB=999, opcode=10; model result -998001 shown; error=0.
- Keys 1,2,3,4 → display_value=123 (4th digit ignored); then add,subtract → opcode=01 and B is still empty.
- Keys 5,divide,2,equals → no computestrobe, error=1, display_value=0; then clear → ENTER_A, error=0.
- Reset asserted during WAIT → next cycle all outputs at reset values; a late alu_result is not captured.
- CALC_CHAIN_EN: 2,add,3,equals then multiply,4,equals → second strobe with regA=5, regB=4, display 20. Result 1000 followed by an operator → ERR.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared constants, key codes, opcodes and FSM states
// for the keypad calculator sequencer.
package calc_pkg;

    localparam int DEF_OPW    = 11;
    localparam int DEF_RESW   = 21;
    localparam int DEF_MAXDIG = 3;
    localparam int OPLIM      = 999;

    localparam logic [4:0] KEY_ADD = 5'd10;
    localparam logic [4:0] KEY_SUB = 5'd11;
    localparam logic [4:0] KEY_MUL = 5'd12;
    localparam logic [4:0] KEY_DIV = 5'd13;
    localparam logic [4:0] KEY_NEG = 5'd14;
    localparam logic [4:0] KEY_EQ  = 5'd15;
    localparam logic [4:0] KEY_CLR = 5'd16;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        S_ENTER_A,
        S_ENTER_B,
        S_EXEC,
        S_WAIT,
        S_SHOW,
        S_ERR
    } state_t;

    function automatic logic is_digit(input logic [4:0] k);
        return k <= 5'd9;
    endfunction

    function automatic logic is_oper(input logic [4:0] k);
        return (k >= KEY_ADD) && (k <= KEY_DIV);
    endfunction

    function automatic logic [1:0] key_to_op(input logic [4:0] k);
        logic [1:0] op;
        unique case (k)
            KEY_SUB: op = OP_SUB;
            KEY_MUL: op = OP_MUL;
            KEY_DIV: op = OP_DIV;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/calc_entry_accum.sv
// calc_entry_accum: decimal operand entry (digits, sign, saturation).
// One instance is shared by A and B; the owner clears it between operands.
module calc_entry_accum
    import calc_pkg::*;
#(
    parameter int OPW    = DEF_OPW,
    parameter int MAXDIG = DEF_MAXDIG,
    localparam int CW    = $clog2(MAXDIG + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_digit_en,
    input  logic [3:0]            i_digit,
    input  logic                  i_negate,
    output logic [CW-1:0]         o_count,
    output logic signed [OPW-1:0] o_next_value
);

    localparam int MW = OPW - 1;

    logic [MW-1:0]         r_mag;
    logic                  r_neg;
    logic [CW-1:0]         r_cnt;
    logic [MW-1:0]         w_base_mag;
    logic                  w_base_neg;
    logic [CW-1:0]         w_base_cnt;
    logic [MW-1:0]         w_mag_nxt;
    logic                  w_neg_nxt;
    logic [CW-1:0]         w_cnt_nxt;
    logic signed [OPW-1:0] w_ext;

    // Next entry state: optional clear first, then digit and/or sign toggle
    always_comb begin
        w_base_mag = i_clear ? '0 : r_mag;
        w_base_neg = i_clear ? 1'b0 : r_neg;
        w_base_cnt = i_clear ? '0 : r_cnt;
        w_mag_nxt  = w_base_mag;
        w_neg_nxt  = w_base_neg;
        w_cnt_nxt  = w_base_cnt;
        if (i_digit_en && (w_base_cnt < CW'(MAXDIG))) begin
            w_mag_nxt = w_base_mag * MW'(10) + MW'(i_digit);
            w_cnt_nxt = w_base_cnt + CW'(1);
        end
        if (i_negate) begin
            w_neg_nxt = ~w_base_neg;
        end
    end

    assign w_ext        = {1'b0, w_mag_nxt};
    assign o_next_value = w_neg_nxt ? -w_ext : w_ext;
    assign o_count      = r_cnt;

    // Entry registers; magnitude and sign kept apart so -0 is representable
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mag <= '0;
            r_neg <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_mag <= w_mag_nxt;
            r_neg <= w_neg_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad control FSM between key decoder and ALU.
// Optional result chaining into a new operation: define CALC_CHAIN_EN.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int OPW    = DEF_OPW,
    parameter int RESW   = DEF_RESW,
    parameter int MAXDIG = DEF_MAXDIG
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            key_valid,
    input  logic [4:0]      key_code,
    output logic [OPW-1:0]  regA,
    output logic [OPW-1:0]  regB,
    output logic [1:0]      opcode,
    output logic            computestrobe,
    input  logic [RESW-1:0] alu_result,
    output logic [RESW-1:0] display_value,
    output logic            busy,
    output logic            error
);

    localparam int CW = $clog2(MAXDIG + 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [OPW-1:0]        r_regA;
    logic [OPW-1:0]        r_regB;
    logic [1:0]            r_opcode;
    logic [RESW-1:0]       r_disp;
    logic                  r_strobe;
    logic                  r_busy;
    logic                  r_err;
    logic                  w_key_ok;
    logic                  w_soft_rst;
    logic                  w_acc_clear;
    logic                  w_acc_digit;
    logic                  w_acc_neg;
    logic                  w_upd_a;
    logic                  w_upd_b;
    logic                  w_op_ld;
    logic                  w_cap;
    logic [CW-1:0]         w_cnt;
    logic signed [OPW-1:0] w_acc_nxt;
    logic [RESW-1:0]       w_acc_disp;
`ifdef CALC_CHAIN_EN
    localparam logic signed [RESW-1:0] LIM = RESW'(OPLIM);
    logic                  w_chain;
    logic                  w_in_range;

    assign w_in_range = ($signed(r_disp) <= LIM) &&
                        ($signed(r_disp) >= -LIM);
`endif

    assign w_key_ok   = key_valid && (r_state != S_EXEC) &&
                        (r_state != S_WAIT);
    assign w_soft_rst = reset || (w_key_ok && (key_code == KEY_CLR));
    assign w_acc_disp = {{(RESW-OPW){w_acc_nxt[OPW-1]}}, w_acc_nxt};

    calc_entry_accum #(
        .OPW    (OPW),
        .MAXDIG (MAXDIG)
    ) u_entry (
        .i_clk        (clock),
        .i_rst        (w_soft_rst),
        .i_clear      (w_acc_clear),
        .i_digit_en   (w_acc_digit),
        .i_digit      (key_code[3:0]),
        .i_negate     (w_acc_neg),
        .o_count      (w_cnt),
        .o_next_value (w_acc_nxt)
    );

    // FSM state register; clear key acts exactly like reset
    always_ff @(posedge clock) begin
        if (w_soft_rst) begin
            r_state <= S_ENTER_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath load enables from state and accepted key
    always_comb begin
        w_state_nxt = r_state;
        w_acc_clear = 1'b0;
        w_acc_digit = 1'b0;
        w_acc_neg   = 1'b0;
        w_upd_a     = 1'b0;
        w_upd_b     = 1'b0;
        w_op_ld     = 1'b0;
        w_cap       = 1'b0;
`ifdef CALC_CHAIN_EN
        w_chain     = 1'b0;
`endif
        unique case (r_state)
            S_ENTER_A: begin
                if (w_key_ok) begin
                    if (is_digit(key_code)) begin
                        w_acc_digit = 1'b1;
                        w_upd_a     = 1'b1;
                    end else if (key_code == KEY_NEG) begin
                        w_acc_neg = 1'b1;
                        w_upd_a   = 1'b1;
                    end else if (is_oper(key_code)) begin
                        w_op_ld     = 1'b1;
                        w_acc_clear = 1'b1;
                        w_upd_b     = 1'b1;
                        w_state_nxt = S_ENTER_B;
                    end
                end
            end
            S_ENTER_B: begin
                if (w_key_ok) begin
                    if (is_digit(key_code)) begin
                        w_acc_digit = 1'b1;
                        w_upd_b     = 1'b1;
                    end else if (key_code == KEY_NEG) begin
                        w_acc_neg = 1'b1;
                        w_upd_b   = 1'b1;
                    end else if (is_oper(key_code)) begin
                        w_op_ld = (w_cnt == '0);
                    end else if (key_code == KEY_EQ) begin
                        w_state_nxt = (r_opcode == OP_DIV) ? S_ERR : S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_cap       = 1'b1;
                w_state_nxt = S_SHOW;
            end
            S_SHOW: begin
                if (w_key_ok) begin
                    if (is_digit(key_code)) begin
                        w_acc_clear = 1'b1;
                        w_acc_digit = 1'b1;
                        w_upd_a     = 1'b1;
                        w_state_nxt = S_ENTER_A;
                    end
`ifdef CALC_CHAIN_EN
                    else if (is_oper(key_code)) begin
                        if (w_in_range) begin
                            w_chain     = 1'b1;
                            w_op_ld     = 1'b1;
                            w_acc_clear = 1'b1;
                            w_upd_b     = 1'b1;
                            w_state_nxt = S_ENTER_B;
                        end else begin
                            w_state_nxt = S_ERR;
                        end
                    end
`endif
                end
            end
            S_ERR: begin
                w_state_nxt = S_ERR;
            end
            default: begin
                w_state_nxt = S_ENTER_A;
            end
        endcase
    end

    // Operands, opcode and display; display follows the operand being typed
    always_ff @(posedge clock) begin
        if (w_soft_rst) begin
            r_regA   <= '0;
            r_regB   <= '0;
            r_opcode <= OP_ADD;
            r_disp   <= '0;
        end else begin
            if (w_upd_a) begin
                r_regA <= w_acc_nxt;
            end
`ifdef CALC_CHAIN_EN
            if (w_chain) begin
                r_regA <= r_disp[OPW-1:0];
            end
`endif
            if (w_upd_b) begin
                r_regB <= w_acc_nxt;
            end
            if (w_op_ld) begin
                r_opcode <= key_to_op(key_code);
            end
            if (w_state_nxt == S_ERR) begin
                r_disp <= '0;
            end else if (w_cap) begin
                r_disp <= alu_result;
            end else if (w_upd_a || w_upd_b) begin
                r_disp <= w_acc_disp;
            end
        end
    end

    // Status outputs registered from the next state so they align with it
    always_ff @(posedge clock) begin
        if (w_soft_rst) begin
            r_strobe <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_strobe <= (w_state_nxt == S_EXEC);
            r_busy   <= (w_state_nxt == S_EXEC) ||
                        (w_state_nxt == S_WAIT);
            r_err    <= (w_state_nxt == S_ERR);
        end
    end

    assign regA          = r_regA;
    assign regB          = r_regB;
    assign opcode        = r_opcode;
    assign computestrobe = r_strobe;
    assign display_value = r_disp;
    assign busy          = r_busy;
    assign error         = r_err;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed key sequences against calc_sequencer
// with a one-cycle registered ALU model.
module tb_calc_sequencer;

    localparam logic [4:0] K_ADD = 5'd10;
    localparam logic [4:0] K_SUB = 5'd11;
    localparam logic [4:0] K_MUL = 5'd12;
    localparam logic [4:0] K_DIV = 5'd13;
    localparam logic [4:0] K_NEG = 5'd14;
    localparam logic [4:0] K_EQ  = 5'd15;
    localparam logic [4:0] K_CLR = 5'd16;

    logic        clock = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [4:0]  key_code;
    logic [10:0] regA;
    logic [10:0] regB;
    logic [1:0]  opcode;
    logic        computestrobe;
    logic [20:0] alu_result = '0;
    logic [20:0] display_value;
    logic        busy;
    logic        error;

    int n_vec    = 0;
    int n_err    = 0;
    int n_strobe = 0;
    int s0;

    calc_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .regA          (regA),
        .regB          (regB),
        .opcode        (opcode),
        .computestrobe (computestrobe),
        .alu_result    (alu_result),
        .display_value (display_value),
        .busy          (busy),
        .error         (error)
    );

    always #5 clock = ~clock;

    function automatic logic [20:0] alu_f(input logic [10:0] a,
                                          input logic [10:0] b,
                                          input logic [1:0]  op);
        int ia;
        int ib;
        int r;
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            2'b00:   r = ia + ib;
            2'b01:   r = ia - ib;
            2'b10:   r = ia * ib;
            default: r = 0;
        endcase
        return r[20:0];
    endfunction

    always @(posedge clock) begin
        if (computestrobe) begin
            alu_result <= alu_f(regA, regB, opcode);
            n_strobe   <= n_strobe + 1;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic press(input logic [4:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clock);
        key_valid = 1'b0;
        key_code  = '0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " regA"}, $signed(regA), 0);
        check({tag, " regB"}, $signed(regB), 0);
        check({tag, " opcode"}, opcode, 0);
        check({tag, " strobe"}, computestrobe, 0);
        check({tag, " disp"}, $signed(display_value), 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " error"}, error, 0);
    endtask

    initial begin
        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = '0;
        repeat (2) @(negedge clock);
        check_reset_vals("rst");
        press(5'd5);
        check("rst beats key", $signed(display_value), 0);
        reset = 1'b0;

        press(5'd1);
        press(5'd2);
        check("t1 dispA", $signed(display_value), 12);
        press(K_ADD);
        check("t1 dispB0", $signed(display_value), 0);
        press(5'd3);
        press(5'd4);
        check("t1 regB", $signed(regB), 34);
        s0 = n_strobe;
        press(K_EQ);
        check("t1 strobe", computestrobe, 1);
        check("t1 busy", busy, 1);
        check("t1 regA", $signed(regA), 12);
        check("t1 regB ex", $signed(regB), 34);
        check("t1 opcode", opcode, 0);
        @(negedge clock);
        check("t1 strobe1cyc", computestrobe, 0);
        @(negedge clock);
        check("t1 result", $signed(display_value), 46);
        check("t1 notbusy", busy, 0);
        check("t1 nstrobe", n_strobe - s0, 1);
        press(5'd7);
        check("t1 newA", $signed(regA), 7);
        check("t1 newA disp", $signed(display_value), 7);

        press(K_CLR);
        check("t2 clr", $signed(regA), 0);
        press(5'd9);
        press(5'd9);
        press(5'd9);
        press(K_NEG);
        check("t2 negA", $signed(regA), -999);
        check("t2 negA disp", $signed(display_value), -999);
        press(K_MUL);
        press(5'd9);
        press(5'd9);
        press(5'd9);
        press(K_EQ);
        check("t2 strobe", computestrobe, 1);
        check("t2 regA", $signed(regA), -999);
        check("t2 regB", $signed(regB), 999);
        check("t2 opcode", opcode, 2);
        press(K_CLR);
        @(negedge clock);
        check("t2 result", $signed(display_value), -998001);
        check("t2 error", error, 0);
        check("t2 busy clr dropped", $signed(regA), -999);

        press(K_CLR);
        press(5'd1);
        press(5'd2);
        press(5'd3);
        press(5'd4);
        check("t3 sat disp", $signed(display_value), 123);
        check("t3 sat regA", $signed(regA), 123);
        press(K_ADD);
        press(K_SUB);
        check("t3 op replace", opcode, 1);
        check("t3 B empty", $signed(regB), 0);
        press(5'd7);
        check("t3 B first", $signed(regB), 7);

        press(K_CLR);
        press(5'd5);
        press(K_DIV);
        press(5'd2);
        check("t4 opcode", opcode, 3);
        s0 = n_strobe;
        press(K_EQ);
        check("t4 error", error, 1);
        check("t4 strobe", computestrobe, 0);
        check("t4 disp", $signed(display_value), 0);
        repeat (3) @(negedge clock);
        check("t4 nstrobe", n_strobe - s0, 0);
        press(5'd3);
        check("t4 err stuck", error, 1);
        check("t4 err disp", $signed(display_value), 0);
        press(K_CLR);
        check("t4 clr err", error, 0);
        check("t4 clr regA", $signed(regA), 0);

        press(K_NEG);
        check("t5 neg0", $signed(regA), 0);
        press(5'd5);
        check("t5 neg5", $signed(regA), -5);
        press(K_ADD);
        press(5'd2);
        press(K_EQ);
        check("t5 strobe", computestrobe, 1);
        @(negedge clock);
        check("t5 wait busy", busy, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_reset_vals("t5 rst");
        repeat (2) @(negedge clock);
        check("t5 late res", $signed(display_value), 0);

`ifdef CALC_CHAIN_EN
        press(5'd2);
        press(K_ADD);
        press(5'd3);
        press(K_EQ);
        repeat (2) @(negedge clock);
        check("ch first", $signed(display_value), 5);
        press(K_MUL);
        check("ch regA", $signed(regA), 5);
        check("ch opcode", opcode, 2);
        press(5'd4);
        press(K_EQ);
        check("ch strobe", computestrobe, 1);
        check("ch regB", $signed(regB), 4);
        repeat (2) @(negedge clock);
        check("ch result", $signed(display_value), 20);
        press(K_CLR);
        press(5'd5);
        press(5'd0);
        press(5'd0);
        press(K_ADD);
        press(5'd5);
        press(5'd0);
        press(5'd0);
        press(K_EQ);
        repeat (2) @(negedge clock);
        check("ch 1000", $signed(display_value), 1000);
        press(K_ADD);
        check("ch ovf err", error, 1);
        check("ch ovf disp", $signed(display_value), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
